// File: rtl/rvx_dbus_ram_responder_pkg.sv
// Shared definitions for the data-bus responders: strobe patterns, responder
// state encoding and the latched request record.
package rvx_dbus_ram_responder_pkg;

    localparam logic [3:0] RVX_STROBE_B0 = 4'b0001;
    localparam logic [3:0] RVX_STROBE_B1 = 4'b0010;
    localparam logic [3:0] RVX_STROBE_B2 = 4'b0100;
    localparam logic [3:0] RVX_STROBE_B3 = 4'b1000;
    localparam logic [3:0] RVX_STROBE_H0 = 4'b0011;
    localparam logic [3:0] RVX_STROBE_H1 = 4'b1100;
    localparam logic [3:0] RVX_STROBE_W  = 4'b1111;

    typedef enum logic [1:0] {
        RVX_DBUS_RESP_IDLE = 2'd0,
        RVX_DBUS_RESP_WAIT = 2'd1,
        RVX_DBUS_RESP_RESP = 2'd2
    } dbus_resp_state_e;

    localparam int WAIT_CNT_W = 4;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wdata;
        logic [3:0]  wstrobe;
        logic        is_write;
        logic        in_range;
        logic        strobe_legal;
        logic        error;
    } dbus_req_t;

    // Only naturally aligned byte, halfword and word accesses are accepted.
    function automatic logic strobe_is_legal(input logic [3:0] strobe);
        logic legal;
        case (strobe)
            RVX_STROBE_B0, RVX_STROBE_B1, RVX_STROBE_B2, RVX_STROBE_B3,
            RVX_STROBE_H0, RVX_STROBE_H1, RVX_STROBE_W: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rvx_dbus_request_check.sv
// Combinational legality check of a data-bus request: address decode window,
// strobe shape and read/write conflict. Shared by all dbus responders.
module rvx_dbus_request_check
    import rvx_dbus_ram_responder_pkg::*;
#(
    parameter int          MEMORY_SIZE  = 8192,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic [31:0] address,
    input  logic [3:0]  strobe,
    input  logic        wrequest,
    input  logic        rrequest,
    output logic        in_range,
    output logic        strobe_legal,
    output logic        error
);

    localparam logic [31:0] SIZE_BYTES = 32'(MEMORY_SIZE);

    logic [31:0] offset;

    // Addresses below the base wrap to a large offset, so a single compare
    // covers both ends of the window.
    assign offset       = address - BASE_ADDRESS;
    assign in_range     = (offset < SIZE_BYTES);
    assign strobe_legal = strobe_is_legal(strobe);
    assign error        = ~in_range | (wrequest & ~strobe_legal) | (wrequest & rrequest);

endmodule

// File: rtl/rvx_dbus_ram_responder.sv
// Data-bus RAM responder: latches a request, waits WAIT_STATES cycles, then
// commits the write or reads the word and returns a one-cycle ready/error pulse.
module rvx_dbus_ram_responder
    import rvx_dbus_ram_responder_pkg::*;
#(
    parameter int          MEMORY_SIZE  = 8192,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          WAIT_STATES  = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] dbus_address,
    input  logic [31:0] dbus_wdata,
    input  logic [3:0]  dbus_wstrobe,
    input  logic        dbus_wrequest,
    input  logic        dbus_rrequest,
    output logic [31:0] dbus_rdata,
    output logic        dbus_ready,
    output logic        dbus_error
);

    localparam int WORDS = MEMORY_SIZE / 4;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [WAIT_CNT_W-1:0] CNT_LAST =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    dbus_resp_state_e      state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    dbus_req_t             req_q, req_d;
    logic                  pend_q, pend_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  chk_in_range;
    logic                  chk_strobe_legal;
    logic                  chk_error;
    logic                  accept;
    logic                  ram_we;
    logic                  ram_re;
    logic [IDX_W-1:0]      ram_idx;
    logic [31:0]           ram_rd_q;
    logic [31:0]           mem [WORDS];

    rvx_dbus_request_check #(
        .MEMORY_SIZE  (MEMORY_SIZE),
        .BASE_ADDRESS (BASE_ADDRESS)
    ) u_check (
        .address      (dbus_address),
        .strobe       (dbus_wstrobe),
        .wrequest     (dbus_wrequest),
        .rrequest     (dbus_rrequest),
        .in_range     (chk_in_range),
        .strobe_legal (chk_strobe_legal),
        .error        (chk_error)
    );

    // No new request is taken while a response is still draining, so a
    // request held through the ready cycle is not accepted twice.
    assign accept = (dbus_wrequest | dbus_rrequest) & ~pend_q & ~ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        pend_d  = 1'b0;
        ready_d = 1'b0;
        error_d = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            RVX_DBUS_RESP_IDLE: begin
                if (accept) begin
                    req_d.address      = dbus_address;
                    req_d.wdata        = dbus_wdata;
                    req_d.wstrobe      = dbus_wstrobe;
                    req_d.is_write     = dbus_wrequest;
                    req_d.in_range     = chk_in_range;
                    req_d.strobe_legal = chk_strobe_legal;
                    req_d.error        = chk_error;
                    cnt_d              = '0;
                    state_d = (WAIT_STATES > 0) ? RVX_DBUS_RESP_WAIT : RVX_DBUS_RESP_RESP;
                end
            end
            RVX_DBUS_RESP_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = RVX_DBUS_RESP_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RVX_DBUS_RESP_RESP: begin
                pend_d  = 1'b1;
                state_d = RVX_DBUS_RESP_IDLE;
            end
            default: state_d = RVX_DBUS_RESP_IDLE;
        endcase

        // Output stage: the RAM word registered in RESP is presented with ready.
        if (pend_q) begin
            ready_d = 1'b1;
            error_d = req_q.error;
            if (req_q.error) begin
                rdata_d = '0;
            end else if (!req_q.is_write) begin
                rdata_d = ram_rd_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= RVX_DBUS_RESP_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            pend_q  <= 1'b0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
            error_q <= error_d;
            rdata_q <= rdata_d;
        end
    end

    assign ram_idx = IDX_W'((req_q.address - BASE_ADDRESS) >> 2);
    assign ram_re  = reset_n & (state_q == RVX_DBUS_RESP_RESP);
    assign ram_we  = ram_re & req_q.is_write & req_q.in_range &
                     req_q.strobe_legal & ~req_q.error;

    // Word-organised RAM with per-byte write enables and a registered read port.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (req_q.wstrobe[i]) begin
                    mem[ram_idx][8*i +: 8] <= req_q.wdata[8*i +: 8];
                end
            end
        end
        if (ram_re) begin
            ram_rd_q <= mem[ram_idx];
        end
    end

    assign dbus_rdata = rdata_q;
    assign dbus_ready = ready_q;
    assign dbus_error = error_q;

endmodule

// File: tb/tb_rvx_dbus_ram_responder.sv
// Directed bench: one responder with no wait states and one with three wait
// states at a non-zero base, driven through a linear sequence of transactions.
module tb_rvx_dbus_ram_responder;

    logic        clock = 1'b0;
    logic        reset_n [2];
    logic [31:0] addr    [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic        wreq    [2];
    logic        rreq    [2];
    logic [31:0] rdata   [2];
    logic        ready   [2];
    logic        error   [2];

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    always #5 clock = ~clock;

    rvx_dbus_ram_responder #(
        .MEMORY_SIZE  (8192),
        .BASE_ADDRESS (32'h0000_0000),
        .WAIT_STATES  (0)
    ) dut0 (
        .clock         (clock),
        .reset_n       (reset_n[0]),
        .dbus_address  (addr[0]),
        .dbus_wdata    (wdata[0]),
        .dbus_wstrobe  (wstrb[0]),
        .dbus_wrequest (wreq[0]),
        .dbus_rrequest (rreq[0]),
        .dbus_rdata    (rdata[0]),
        .dbus_ready    (ready[0]),
        .dbus_error    (error[0])
    );

    rvx_dbus_ram_responder #(
        .MEMORY_SIZE  (8192),
        .BASE_ADDRESS (32'h0001_0000),
        .WAIT_STATES  (3)
    ) dut1 (
        .clock         (clock),
        .reset_n       (reset_n[1]),
        .dbus_address  (addr[1]),
        .dbus_wdata    (wdata[1]),
        .dbus_wstrobe  (wstrb[1]),
        .dbus_wrequest (wreq[1]),
        .dbus_rrequest (rreq[1]),
        .dbus_rdata    (rdata[1]),
        .dbus_ready    (ready[1]),
        .dbus_error    (error[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request on responder k, optionally moving the address after
    // the first wait edge, and returns edges from accept to ready plus the response.
    task automatic txn(input int k, input logic we, input logic re,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic chg, input logic [31:0] a2,
                       output int lat, output logic e, output logic [31:0] rd);
        @(negedge clock);
        wreq[k]  = we;
        rreq[k]  = re;
        addr[k]  = a;
        wdata[k] = d;
        wstrb[k] = s;
        @(posedge clock);
        lat = 0;
        while (lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
            if (chg && lat == 1) addr[k] = a2;
            if (ready[k]) break;
        end
        e  = error[k];
        rd = rdata[k];
        wreq[k] = 1'b0;
        rreq[k] = 1'b0;
        @(posedge clock);
        #1;
        check("ready_one_cycle", {31'b0, ready[k]}, 32'd0);
        $display("txn dut%0d we=%0b re=%0b addr=0x%08h wdata=0x%08h strb=%b lat=%0d err=%0b rdata=0x%08h",
                 k, we, re, a, d, s, lat, e, rd);
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [31:0] rd;
        logic        seen;

        for (int k = 0; k < 2; k++) begin
            reset_n[k] = 1'b0;
            addr[k]    = '0;
            wdata[k]   = '0;
            wstrb[k]   = '0;
            wreq[k]    = 1'b0;
            rreq[k]    = 1'b0;
        end
        repeat (3) @(posedge clock);
        #1;
        check("rst_rdata0", rdata[0], 32'd0);
        check("rst_ready0", {31'b0, ready[0]}, 32'd0);
        check("rst_error0", {31'b0, error[0]}, 32'd0);
        check("rst_rdata1", rdata[1], 32'd0);
        check("rst_ready1", {31'b0, ready[1]}, 32'd0);
        @(negedge clock);
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;

        // Full-word write and read back, no wait states.
        txn(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 0, lat, e, rd);
        check("w10_lat", lat, 2);
        check("w10_err", {31'b0, e}, 0);
        txn(0, 0, 1, 32'h10, 32'h0, 4'b0000, 0, 0, lat, e, rd);
        check("r10_lat", lat, 2);
        check("r10_err", {31'b0, e}, 0);
        check("r10_data", rd, 32'hDEADBEEF);

        // Byte and halfword lane merges.
        txn(0, 1, 0, 32'h20, 32'h0000_0000, 4'b1111, 0, 0, lat, e, rd);
        txn(0, 1, 0, 32'h20, 32'h00AB_0000, 4'b0100, 0, 0, lat, e, rd);
        check("wb2_err", {31'b0, e}, 0);
        txn(0, 0, 1, 32'h20, 32'h0, 4'b0000, 0, 0, lat, e, rd);
        check("rb2_data", rd, 32'h00AB_0000);
        txn(0, 1, 0, 32'h22, 32'h1234_0000, 4'b1100, 0, 0, lat, e, rd);
        txn(0, 0, 1, 32'h20, 32'h0, 4'b0000, 0, 0, lat, e, rd);
        check("rh1_data", rd, 32'h1234_0000);
        txn(0, 1, 0, 32'h20, 32'h0000_00CD, 4'b0001, 0, 0, lat, e, rd);
        txn(0, 0, 1, 32'h21, 32'h0, 4'b0000, 0, 0, lat, e, rd);
        check("rb0_data", rd, 32'h1234_00CD);

        // Illegal strobes leave memory untouched.
        txn(0, 1, 0, 32'h30, 32'h1122_3344, 4'b1111, 0, 0, lat, e, rd);
        txn(0, 1, 0, 32'h30, 32'hFFFF_FFFF, 4'b0101, 0, 0, lat, e, rd);
        check("s0101_lat", lat, 2);
        check("s0101_err", {31'b0, e}, 1);
        txn(0, 1, 0, 32'h30, 32'hFFFF_FFFF, 4'b0000, 0, 0, lat, e, rd);
        check("s0000_err", {31'b0, e}, 1);
        txn(0, 0, 1, 32'h30, 32'h0, 4'b0000, 0, 0, lat, e, rd);
        check("r30_err", {31'b0, e}, 0);
        check("r30_data", rd, 32'h1122_3344);

        // Address one past the window, and the last legal word.
        txn(0, 0, 1, 32'h2000, 32'h0, 4'b0000, 0, 0, lat, e, rd);
        check("oor_err", {31'b0, e}, 1);
        check("oor_data", rd, 32'd0);
        txn(0, 1, 0, 32'h1FFC, 32'hA5A5_5A5A, 4'b1111, 0, 0, lat, e, rd);
        txn(0, 0, 1, 32'h1FFC, 32'h0, 4'b0000, 0, 0, lat, e, rd);
        check("top_err", {31'b0, e}, 0);
        check("top_data", rd, 32'hA5A5_5A5A);

        // Read and write together is rejected without writing.
        txn(0, 1, 1, 32'h10, 32'h0000_0000, 4'b1111, 0, 0, lat, e, rd);
        check("both_err", {31'b0, e}, 1);
        check("both_data", rd, 32'd0);
        txn(0, 0, 1, 32'h10, 32'h0, 4'b0000, 0, 0, lat, e, rd);
        check("both_nowr", rd, 32'hDEADBEEF);

        // Three wait states at base 0x10000.
        txn(1, 1, 0, 32'h0001_0040, 32'hCAFE_F00D, 4'b1111, 0, 0, lat, e, rd);
        check("ws3_w_lat", lat, 5);
        check("ws3_w_err", {31'b0, e}, 0);
        txn(1, 1, 0, 32'h0001_0044, 32'h5566_7788, 4'b1111, 0, 0, lat, e, rd);
        txn(1, 0, 1, 32'h0001_0040, 32'h0, 4'b0000, 1, 32'h0001_0044, lat, e, rd);
        check("ws3_r_lat", lat, 5);
        check("ws3_r_data", rd, 32'hCAFE_F00D);
        txn(1, 0, 1, 32'h0000_FFFC, 32'h0, 4'b0000, 0, 0, lat, e, rd);
        check("below_err", {31'b0, e}, 1);
        check("below_data", rd, 32'd0);

        // Reset while waiting drops the write and any response.
        txn(1, 0, 1, 32'h0001_0044, 32'h0, 4'b0000, 0, 0, lat, e, rd);
        check("pre_rst_data", rd, 32'h5566_7788);
        @(negedge clock);
        wreq[1]  = 1'b1;
        addr[1]  = 32'h0001_0040;
        wdata[1] = 32'hFFFF_FFFF;
        wstrb[1] = 4'b1111;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_n[1] = 1'b0;
        wreq[1]    = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            seen = seen | ready[1];
        end
        check("rst_mid_rdata", rdata[1], 32'd0);
        check("rst_mid_error", {31'b0, error[1]}, 32'd0);
        @(negedge clock);
        reset_n[1] = 1'b1;
        repeat (8) begin
            @(posedge clock);
            #1;
            seen = seen | ready[1];
        end
        check("rst_no_ready", {31'b0, seen}, 32'd0);
        $display("txn dut1 reset during wait, ready_seen=%0b", seen);
        txn(1, 0, 1, 32'h0001_0040, 32'h0, 4'b0000, 0, 0, lat, e, rd);
        check("rst_r_lat", lat, 5);
        check("rst_r_data", rd, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/rvx_dbus_ram_responder.md
Name: rvx_dbus_ram_responder

Overview:
- Data-bus responder (slave end) for the core's store/load path.
- Accepts word-aligned write data with byte strobes, and read requests, from the core data bus.
- Validates address range and strobe legality, applies byte-lane writes to an internal word-organised RAM, and returns full aligned read words.
- Completes each transaction with a one-cycle ready/error pulse after a configurable number of wait states.
- Sits between the core dbus and on-chip data memory.

Parameters:
- MEMORY_SIZE, 8192: RAM size in bytes; must be a multiple of 4 and a power of two.
- BASE_ADDRESS, 32'h00000000: first byte address decoded by this responder; aligned to MEMORY_SIZE.
- WAIT_STATES, 0: extra cycles inserted between request accept and response; range 0..15.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- dbus_address  in  32  byte address; bits [1:0] are ignored for array indexing.
- dbus_wdata  in  32  write data, already placed in its byte lanes.
- dbus_wstrobe  in  4  byte-lane write enables.
- dbus_wrequest  in  1  write request; held by the initiator until the response.
- dbus_rrequest  in  1  read request; held by the initiator until the response.
- dbus_rdata  out  32  read data, full aligned word.
- dbus_ready  out  1  one-cycle completion pulse.
- dbus_error  out  1  one-cycle error pulse, coincident with dbus_ready.

Behaviour:
- One clock domain. Reset is synchronous and active-low on reset_n; all state is updated only on the rising edge of clock.
- Reset values: dbus_rdata=0, dbus_ready=0, dbus_error=0, state=IDLE, wait counter=0. RAM contents are not cleared.
- State machine states: IDLE, WAIT, RESP.
- IDLE:
  - Accepts a request when dbus_wrequest or dbus_rrequest is high.
  - Latches address, wdata, wstrobe, request type and error flag.
  - Goes to WAIT if WAIT_STATES>0, else to RESP.
- WAIT: counter counts up from 0; at WAIT_STATES-1 it goes to RESP.
- RESP, for one cycle:
  - Commits a write, or samples the read word.
  - Drives dbus_ready=1, and dbus_error=1 if the error flag is set.
  - Returns to IDLE.
- Latency: dbus_ready rises WAIT_STATES+2 rising edges after the first edge on which the request is sampled high. With WAIT_STATES=0 this is 2 edges (the request is accepted on edge 0, ready is high after edge 2).
- Back-to-back: the initiator must drop or replace its request in the cycle after the ready pulse. A request still high in the cycle after ready is treated as a new transaction.
- Legal strobes: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Error conditions:
  - The address lies outside [BASE_ADDRESS, BASE_ADDRESS+MEMORY_SIZE).
  - A write carries an illegal strobe, including 0000.
  - dbus_wrequest and dbus_rrequest are both high at accept.
- On error: no RAM write, dbus_rdata=0, dbus_ready=1, dbus_error=1.
- Write: for each lane i with wstrobe[i]=1, RAM[word][8i+7:8i] takes wdata[8i+7:8i]. Other lanes are unchanged. The write is visible to any read accepted after the ready pulse.
- Read: dbus_rdata = RAM[word] (all 4 lanes). Lane extraction and sign extension are the initiator's job.
- dbus_rdata holds its last value between responses; it is updated only in RESP.
- Word index = (dbus_address - BASE_ADDRESS) >> 2, width log2(MEMORY_SIZE/4). Index wrap-around is impossible because out-of-range addresses are rejected.
- Request inputs that change during WAIT or RESP are ignored, since the latched copies are used.
- Reset asserted in any state:
  - Returns to IDLE and clears the outputs on the next edge.
  - A transaction in flight is dropped, with no RAM write and no ready pulse.
  - The initiator must re-issue it.

Decomposition:
- Add to rvx_constants.vh:
  - strobe pattern constants: RVX_STROBE_B0..B3, RVX_STROBE_H0, RVX_STROBE_H1, RVX_STROBE_W.
  - state encodings: RVX_DBUS_RESP_IDLE, RVX_DBUS_RESP_WAIT, RVX_DBUS_RESP_RESP.
- Sub-module rvx_dbus_request_check (combinational):
  - inputs: address, strobe, request bits.
  - outputs: in_range, strobe_legal, error.
  - it is reused by future peripheral responders.

Test Plan:
- WAIT_STATES=0. Write 0xDEADBEEF to 0x10 with strobe 1111, then read 0x10 -> ready 2 edges after each request, error=0, rdata=0xDEADBEEF.
- Prefill 0x20=0x00000000. Write wdata=0x00AB0000, strobe 0100, then read -> 0x00AB0000. Then write 0x12340000, strobe 1100, then read -> 0x12340000.
- WAIT_STATES=3. Read request held high -> ready after exactly 5 edges; changing the address mid-wait does not alter the returned word.
- Write with strobe 0101 to 0x30 (which holds 0x11223344) -> ready=1, error=1; a read of 0x30 returns 0x11223344.
- Read at BASE_ADDRESS+MEMORY_SIZE -> error=1, rdata=0. Simultaneous rrequest and wrequest -> error=1, no write.
- WAIT_STATES=3. Write issued, reset_n pulled low during WAIT -> ready never pulses, state is IDLE, the target word is unchanged after reset is released and the word is read.
